regfile_read_ctrl: RTL and testbench
====================================

Name: regfile_read_ctrl

Overview:
Read-side controller for the 32x32 register file built from the enable/clear flip-flop array. It accepts dual-operand read requests over a valid/ready handshake and selects both operands from the flattened register contents. Same-cycle writes are forwarded past the flip-flops. Results are held in a 2-entry response buffer, so a stalled consumer never loses data. It sits between the register storage array and the execute/consumer stage.

Parameters:
DATA_W, 32, width of each register and read result
ADDR_W, 5, register address width
NUM_REGS, 32, register count (2**ADDR_W)
BUF_DEPTH, 2, response buffer entries (fixed at 2; other values unsupported)

Ports:
clk  in  1  clock; all state updates on rising edge
clr  in  1  synchronous active-high reset
reg_bus  in  NUM_REGS*DATA_W  flattened register q outputs; reg i at bits [i*DATA_W +: DATA_W]
req_valid  in  1  read request present
req_ready  out  1  controller can accept a request
req_addr_a  in  ADDR_W  operand A register index
req_addr_b  in  ADDR_W  operand B register index
wr_en  in  1  write port is committing this cycle
wr_addr  in  ADDR_W  write target index
wr_data  in  DATA_W  write data
rsp_valid  out  1  head response valid
rsp_ready  in  1  consumer accepts head response
rsp_data_a  out  DATA_W  operand A result
rsp_data_b  out  DATA_W  operand B result
rsp_count  out  2  occupied buffer entries (0..2)

Behaviour:
- Reset (clr high at a rising edge): buffer emptied; rsp_count=0; rsp_valid=0; rsp_data_a=rsp_data_b=0; both entries cleared to 0. While clr is high, req_ready=0 and no request is accepted.
- req_ready = (rsp_count < 2) and not clr. It is a function of registered count only; there is no combinational path from rsp_ready.
- Accept: req_valid & req_ready at edge N. Operands are captured into the tail entry at edge N.
- Latency: rsp_valid is high in cycle N+1 when the buffer was empty.
- Operand select, for each of A and B independently:
  - addr==0 gives 0, regardless of reg_bus or a write to 0.
  - Else, if wr_en & wr_addr==addr in the accept cycle, gives wr_data (bypass).
  - Else gives reg_bus slice [addr].
- Snapshot semantics: a captured entry is never updated by later writes.
- Pop: rsp_valid & rsp_ready at an edge removes the head. The second entry, if present, becomes head next cycle.
- Simultaneous push and pop:
  - With count 1, count stays 1 and the new entry becomes head.
  - With count 2, push is impossible (req_ready=0); the pop frees a slot and req_ready rises next cycle.
- Storage: 2 entries, read/write pointers (1 bit each, wrap 1 to 0), count 0..2.
- rsp_data_a/b always show the head entry. When empty they hold the last popped value; the consumer must qualify with rsp_valid.
- rsp_valid = (rsp_count != 0). Outputs are stable while rsp_valid & !rsp_ready.
- Reset mid-operation: pending entries are discarded with no response. Requests presented during clr are dropped.
- Address out of range cannot occur (ADDR_W bits cover NUM_REGS exactly).

Decomposition:
- Shared package regfile_pkg holds DATA_W, ADDR_W, NUM_REGS, and the response entry struct {data_a, data_b}. The write port and flip-flop array use the same constants.
- One sub-module, rf_operand_sel: takes reg_bus, addr, wr_en, wr_addr, wr_data and returns the selected operand (zero-register check, bypass, mux). It is instantiated twice (A, B).
- Buffer and pointer logic live in the top module.

Test Plan:
- Reset then idle: clr held 2 cycles -> rsp_valid=0, rsp_count=0, rsp_data_a/b=0, req_ready=0 during clr and 1 the cycle after.
- Basic read: reg3=0x0000_00AA, reg7=0x1234_5678; request (3,7) with rsp_ready=1 -> next cycle rsp_valid=1, a=0x0000_00AA, b=0x1234_5678, then count returns to 0.
- Zero and bypass: request (0,5) with wr_en=1, wr_addr=5, wr_data=0xDEAD_BEEF, reg5=0x1 -> a=0, b=0xDEAD_BEEF. A second request with wr_addr=0, wr_data=0xFFFF_FFFF and addr_a=0 -> a=0.
- Backpressure fill: rsp_ready=0, issue requests (1,2),(3,4),(5,6) -> first two accepted, count=2, req_ready=0, third held. Raise rsp_ready -> responses pop in order (1,2),(3,4), then (5,6) is accepted.
- Snapshot: with rsp_ready=0, capture reg9=0x11. Then write reg9=0x22 -> head still shows 0x11 until popped.
- Reset mid-operation: count=2, assert clr one cycle -> count=0, rsp_valid=0 next cycle; neither entry is ever presented.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register file read path.
// The write port and the flip-flop storage array use the same constants,
// so every block agrees on register width, count and address width.
package regfile_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned ADDR_W    = 5;
    localparam int unsigned NUM_REGS  = 1 << ADDR_W;
    // The response buffer is built as a two-entry ring with 1-bit pointers.
    localparam int unsigned BUF_DEPTH = 2;

    // One buffered read response: both operands captured together.
    typedef struct packed {
        logic [DATA_W-1:0] data_a;
        logic [DATA_W-1:0] data_b;
    } rsp_entry_t;

endpackage

// File: rtl/rf_operand_sel.sv
// Operand selector for one read port of the register file.
// Ports:
//   reg_bus_i  flattened register contents, reg i at [i*DATA_W +: DATA_W]
//   addr_i     register index to read
//   wr_en_i    write port committing this cycle
//   wr_addr_i  write target index
//   wr_data_i  write data
//   operand_o  selected operand
// Register 0 always reads as zero; a same-cycle write to the requested
// register is forwarded ahead of the flip-flop contents.
module rf_operand_sel
    import regfile_pkg::*;
(
    input  logic [NUM_REGS*DATA_W-1:0] reg_bus_i,
    input  logic [ADDR_W-1:0]          addr_i,
    input  logic                       wr_en_i,
    input  logic [ADDR_W-1:0]          wr_addr_i,
    input  logic [DATA_W-1:0]          wr_data_i,
    output logic [DATA_W-1:0]          operand_o
);

    always_comb begin
        operand_o = '0;
        if (addr_i == '0) begin
            // Zero register wins even over a write targeting it.
            operand_o = '0;
        end else if (wr_en_i && (wr_addr_i == addr_i)) begin
            operand_o = wr_data_i;
        end else begin
            operand_o = reg_bus_i[32'(addr_i) * DATA_W +: DATA_W];
        end
    end

endmodule

// File: rtl/regfile_read_ctrl.sv
// Read-side controller for the 32x32 register file.
// Accepts dual-operand read requests over valid/ready, selects both operands
// (with write bypass), and holds results in a 2-entry response buffer.
// Ports:
//   clk, clr                 clock and synchronous active-high reset
//   reg_bus                  flattened register contents
//   req_valid/req_ready      request handshake
//   req_addr_a/req_addr_b    operand indices
//   wr_en/wr_addr/wr_data    write port activity, used for bypass
//   rsp_valid/rsp_ready      response handshake
//   rsp_data_a/rsp_data_b    head entry operands
//   rsp_count                occupied buffer entries (0..2)
module regfile_read_ctrl
    import regfile_pkg::*;
(
    input  logic                       clk,
    input  logic                       clr,
    input  logic [NUM_REGS*DATA_W-1:0] reg_bus,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [ADDR_W-1:0]          req_addr_a,
    input  logic [ADDR_W-1:0]          req_addr_b,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DATA_W-1:0]          rsp_data_a,
    output logic [DATA_W-1:0]          rsp_data_b,
    output logic [1:0]                 rsp_count
);

    rsp_entry_t        entry_q [BUF_DEPTH];
    rsp_entry_t        entry_d [BUF_DEPTH];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic [DATA_W-1:0] sel_a, sel_b;
    logic              push, pop;
    rsp_entry_t        head;

    rf_operand_sel u_sel_a (
        .reg_bus_i (reg_bus),
        .addr_i    (req_addr_a),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .operand_o (sel_a)
    );

    rf_operand_sel u_sel_b (
        .reg_bus_i (reg_bus),
        .addr_i    (req_addr_b),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .operand_o (sel_b)
    );

    // Ready depends only on registered occupancy, never on rsp_ready.
    assign req_ready = (count_q != 2'd2) && !clr;
    assign rsp_valid = (count_q != 2'd0);
    assign push      = req_valid && req_ready;
    assign pop       = rsp_valid && rsp_ready;

    always_comb begin
        entry_d  = entry_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            entry_d[wr_ptr_q] = '{data_a: sel_a, data_b: sel_b};
            wr_ptr_d          = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            entry_q  <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            entry_q  <= entry_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // When empty, the slot just behind the read pointer is the last popped
    // entry, so the outputs keep showing it instead of stale older data.
    always_comb begin
        head = (count_q == 2'd0) ? entry_q[~rd_ptr_q] : entry_q[rd_ptr_q];
    end

    assign rsp_data_a = head.data_a;
    assign rsp_data_b = head.data_b;
    assign rsp_count  = count_q;

endmodule

// File: tb/tb_regfile_read_ctrl.sv
module tb_regfile_read_ctrl;
    import regfile_pkg::*;

    logic                       clk = 1'b0;
    logic                       clr;
    logic [NUM_REGS*DATA_W-1:0] reg_bus;
    logic                       req_valid;
    logic                       req_ready;
    logic [ADDR_W-1:0]          req_addr_a;
    logic [ADDR_W-1:0]          req_addr_b;
    logic                       wr_en;
    logic [ADDR_W-1:0]          wr_addr;
    logic [DATA_W-1:0]          wr_data;
    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [DATA_W-1:0]          rsp_data_a;
    logic [DATA_W-1:0]          rsp_data_b;
    logic [1:0]                 rsp_count;

    // Behavioural storage array and response queue model.
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] mq_a [$];
    logic [DATA_W-1:0] mq_b [$];
    logic [DATA_W-1:0] last_a, last_b;
    bit                can_push;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    regfile_read_ctrl dut (
        .clk        (clk),
        .clr        (clr),
        .reg_bus    (reg_bus),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr_a (req_addr_a),
        .req_addr_b (req_addr_b),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data_a (rsp_data_a),
        .rsp_data_b (rsp_data_b),
        .rsp_count  (rsp_count)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) reg_bus[i*DATA_W +: DATA_W] = regs[i];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] model_op(input logic [ADDR_W-1:0] a);
        if (a == 0) return '0;
        if (wr_en && wr_addr == a) return wr_data;
        return regs[a];
    endfunction

    // Model: FIFO of captured operand pairs, updated on each rising edge.
    initial begin
        for (int i = 0; i < NUM_REGS; i++) regs[i] = '0;
        last_a = '0;
        last_b = '0;
        forever begin
            @(posedge clk);
            if (clr) begin
                mq_a.delete();
                mq_b.delete();
                last_a = '0;
                last_b = '0;
            end else begin
                can_push = (mq_a.size() < 2);
                if (mq_a.size() != 0 && rsp_ready) begin
                    last_a = mq_a.pop_front();
                    last_b = mq_b.pop_front();
                end
                if (can_push && req_valid) begin
                    mq_a.push_back(model_op(req_addr_a));
                    mq_b.push_back(model_op(req_addr_b));
                end
            end
            if (wr_en) regs[wr_addr] <= wr_data;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("rsp_valid", 32'(rsp_valid), 32'(mq_a.size() != 0));
            check("rsp_count", 32'(rsp_count), 32'(mq_a.size()));
            check("req_ready", 32'(req_ready), 32'((mq_a.size() < 2) && !clr));
            if (mq_a.size() != 0) begin
                check("head_a", rsp_data_a, mq_a[0]);
                check("head_b", rsp_data_b, mq_b[0]);
            end else begin
                check("idle_a", rsp_data_a, last_a);
                check("idle_b", rsp_data_b, last_b);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic req(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
        req_valid  = 1'b1;
        req_addr_a = a;
        req_addr_b = b;
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    initial begin
        clr        = 1'b1;
        req_valid  = 1'b0;
        req_addr_a = '0;
        req_addr_b = '0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        rsp_ready  = 1'b0;

        // Reset held two cycles.
        step();
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_count", 32'(rsp_count), 32'd0);
        check("rst_a", rsp_data_a, 32'h0);
        check("rst_b", rsp_data_b, 32'h0);
        check("rst_ready", 32'(req_ready), 32'd0);
        chk_en = 1'b1;
        step();
        clr = 1'b0;
        #1;
        check("ready_after_clr", 32'(req_ready), 32'd1);

        // Preload the storage array through the write port.
        wr(5'd1, 32'h0000_0101);
        wr(5'd2, 32'h0000_0102);
        wr(5'd3, 32'h0000_00AA);
        wr(5'd4, 32'h0000_0104);
        wr(5'd5, 32'h0000_0001);
        wr(5'd6, 32'h0000_0106);
        wr(5'd7, 32'h1234_5678);
        wr(5'd9, 32'h0000_0011);

        // Basic read.
        rsp_ready = 1'b1;
        req(5'd3, 5'd7);
        step();
        req_valid = 1'b0;
        check("basic_valid", 32'(rsp_valid), 32'd1);
        check("basic_a", rsp_data_a, 32'h0000_00AA);
        check("basic_b", rsp_data_b, 32'h1234_5678);
        step();
        check("basic_drain", 32'(rsp_count), 32'd0);

        // Zero register and write bypass.
        req(5'd0, 5'd5);
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
        step();
        req_valid = 1'b0; wr_en = 1'b0;
        check("zero_a", rsp_data_a, 32'h0);
        check("bypass_b", rsp_data_b, 32'hDEAD_BEEF);
        req(5'd0, 5'd3);
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
        step();
        req_valid = 1'b0; wr_en = 1'b0;
        check("zero_wr0_a", rsp_data_a, 32'h0);
        check("zero_wr0_b", rsp_data_b, 32'h0000_00AA);
        step();

        // Backpressure fill and ordered drain.
        rsp_ready = 1'b0;
        req(5'd1, 5'd2);
        step();
        req(5'd3, 5'd4);
        step();
        req(5'd5, 5'd6);
        step();
        check("full_count", 32'(rsp_count), 32'd2);
        check("full_ready", 32'(req_ready), 32'd0);
        check("full_head_a", rsp_data_a, 32'h0000_0101);
        check("full_head_b", rsp_data_b, 32'h0000_0102);
        step();
        check("held_count", 32'(rsp_count), 32'd2);
        rsp_ready = 1'b1;
        step();
        check("pop1_a", rsp_data_a, 32'h0000_00AA);
        check("pop1_b", rsp_data_b, 32'h0000_0104);
        check("pop1_ready", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        check("pushpop_count", 32'(rsp_count), 32'd1);
        check("pushpop_a", rsp_data_a, 32'hDEAD_BEEF);
        check("pushpop_b", rsp_data_b, 32'h0000_0106);
        step();
        check("drain_count", 32'(rsp_count), 32'd0);

        // Snapshot: later write must not alter a captured entry.
        rsp_ready = 1'b0;
        req(5'd9, 5'd9);
        step();
        req_valid = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h0000_0022;
        step();
        wr_en = 1'b0;
        check("snap_a", rsp_data_a, 32'h0000_0011);
        check("snap_b", rsp_data_b, 32'h0000_0011);
        step();
        check("snap_hold", rsp_data_a, 32'h0000_0011);
        rsp_ready = 1'b1;
        step();
        check("snap_pop", 32'(rsp_count), 32'd0);
        req(5'd9, 5'd0);
        step();
        req_valid = 1'b0;
        check("after_wr_a", rsp_data_a, 32'h0000_0022);
        check("after_wr_b", rsp_data_b, 32'h0);
        step();

        // Reset with a full buffer; request during clr is dropped.
        rsp_ready = 1'b0;
        req(5'd1, 5'd2);
        step();
        req(5'd3, 5'd4);
        step();
        check("pre_clr_count", 32'(rsp_count), 32'd2);
        clr = 1'b1;
        req(5'd5, 5'd6);
        #1;
        check("clr_ready", 32'(req_ready), 32'd0);
        step();
        clr = 1'b0;
        req_valid = 1'b0;
        check("post_clr_count", 32'(rsp_count), 32'd0);
        check("post_clr_valid", 32'(rsp_valid), 32'd0);
        check("post_clr_a", rsp_data_a, 32'h0);
        rsp_ready = 1'b1;
        repeat (3) step();
        check("post_clr_idle", 32'(rsp_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
